// File: rtl/gerenciador_atributos.sv
// gerenciador_atributos: keeps the pet's three vital attributes (saciedade,
// energia, felicidade). It updates them once per second according to the
// one-hot state from the state controller, and raises a sticky `morreu` flag
// when any attribute reaches zero.
// Optional feature: define ATRIB_ALERTA_EN to add the registered `alerta`
// low-attribute flags output.
module gerenciador_atributos #(
  parameter int CLK_HZ        = 100,
  parameter int W             = 4,
  parameter int MAX_ATRIB     = 15,
  parameter int INICIAL       = 10,
  parameter int PERIODO_DECAI = 5,
  parameter int LIMIAR_ALERTA = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   estado,
  output logic [W-1:0] saciedade,
  output logic [W-1:0] energia,
  output logic [W-1:0] felicidade,
  output logic         morreu
`ifdef ATRIB_ALERTA_EN
  ,
  output logic [2:0]   alerta
`endif
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (PERIODO_DECAI > 1) ? $clog2(PERIODO_DECAI) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(PERIODO_DECAI - 1);
  localparam logic [W-1:0]  MAX_V    = W'(MAX_ATRIB);
  localparam logic [W-1:0]  INI_V    = W'(INICIAL);

  localparam logic [3:0] EST_IDLE       = 4'b0001;
  localparam logic [3:0] EST_COMENDO    = 4'b0010;
  localparam logic [3:0] EST_DORMINDO   = 4'b0100;
  localparam logic [3:0] EST_DANDO_AULA = 4'b1000;

  // Reject configurations that cannot be represented in W bits.
  if (MAX_ATRIB > (2 ** W) - 1) begin : g_max_invalid
    $error("MAX_ATRIB does not fit in W bits");
  end
  if (INICIAL > MAX_ATRIB) begin : g_inicial_invalid
    $error("INICIAL exceeds MAX_ATRIB");
  end
  if (LIMIAR_ALERTA > MAX_ATRIB) begin : g_limiar_invalid
    $error("LIMIAR_ALERTA exceeds MAX_ATRIB");
  end

  typedef enum logic {
    VIVO  = 1'b0,
    MORTO = 1'b1
  } vida_t;

  vida_t          state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dec_q, dec_d;
  logic [W-1:0]   sac_q, sac_d;
  logic [W-1:0]   ene_q, ene_d;
  logic [W-1:0]   fel_q, fel_d;
  logic           tick;
  logic           any_zero;

  // Saturating increment: holds at MAX_ATRIB.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v >= MAX_V) return MAX_V;
    return v + 1'b1;
  endfunction

  // Saturating decrement: holds at zero.
  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
    if (v == '0) return '0;
    return v - 1'b1;
  endfunction

  assign tick     = (cnt_q == CNT_LAST);
  assign any_zero = (sac_q == '0) || (ene_q == '0) || (fel_q == '0);

  // One-second tick counter; free-running even after death.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Life FSM next state: any attribute at zero kills the pet for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      VIVO:    if (any_zero) state_d = MORTO;
      MORTO:   state_d = MORTO;
      default: state_d = MORTO;
    endcase
  end

  // Life FSM state register; only reset leaves MORTO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= VIVO;
    else        state_q <= state_d;
  end

  // Attribute and decay-counter next state; estado only matters at the tick.
  always_comb begin
    sac_d = sac_q;
    ene_d = ene_q;
    fel_d = fel_q;
    dec_d = dec_q;
    // Any cycle outside IDLE (including invalid codes) restarts the decay period.
    if (estado != EST_IDLE) dec_d = '0;
    if (tick && state_q == VIVO) begin
      case (estado)
        EST_IDLE: begin
          if (dec_q == DEC_LAST) begin
            sac_d = sat_dec(sac_q);
            ene_d = sat_dec(ene_q);
            fel_d = sat_dec(fel_q);
            dec_d = '0;
          end else begin
            dec_d = dec_q + 1'b1;
          end
        end
        EST_COMENDO:    sac_d = sat_inc(sac_q);
        EST_DORMINDO:   ene_d = sat_inc(ene_q);
        EST_DANDO_AULA: begin
          fel_d = sat_inc(fel_q);
          ene_d = sat_dec(ene_q);
        end
        default: ;
      endcase
    end
  end

  // Attribute and decay-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sac_q <= INI_V;
      ene_q <= INI_V;
      fel_q <= INI_V;
      dec_q <= '0;
    end else begin
      sac_q <= sac_d;
      ene_q <= ene_d;
      fel_q <= fel_d;
      dec_q <= dec_d;
    end
  end

  assign saciedade  = sac_q;
  assign energia    = ene_q;
  assign felicidade = fel_q;
  assign morreu     = (state_q == MORTO);

`ifdef ATRIB_ALERTA_EN
  localparam logic [W-1:0] LIM_V = W'(LIMIAR_ALERTA);

  logic [2:0] alerta_q, alerta_d;

  // Low-attribute flags trail the attributes by one cycle; all set once dead.
  always_comb begin
    alerta_d = {(fel_q <= LIM_V), (ene_q <= LIM_V), (sac_q <= LIM_V)};
    if (state_d == MORTO) alerta_d = 3'b111;
  end

  // Alert flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alerta_q <= 3'b000;
    else        alerta_q <= alerta_d;
  end

  assign alerta = alerta_q;
`endif

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Self-checking bench for gerenciador_atributos: table of scenario vectors,
// hand-written death/reset/alert sequences, and a randomized run against a
// behavioural model.
module tb_gerenciador_atributos;

  localparam int TB_CLK = 4;
  localparam int TB_PER = 2;
  localparam int TB_MAX = 15;
  localparam int TB_LIM = 3;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic [3:0] est_a, est_b;
  logic [3:0] sac_a, ene_a, fel_a, sac_b, ene_b, fel_b;
  logic       mor_a, mor_b;
`ifdef ATRIB_ALERTA_EN
  logic [2:0] al_a, al_b;
`endif

  gerenciador_atributos #(
    .CLK_HZ(TB_CLK), .W(4), .MAX_ATRIB(TB_MAX), .INICIAL(10),
    .PERIODO_DECAI(TB_PER), .LIMIAR_ALERTA(TB_LIM)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .estado(est_a),
    .saciedade(sac_a), .energia(ene_a), .felicidade(fel_a), .morreu(mor_a)
`ifdef ATRIB_ALERTA_EN
    , .alerta(al_a)
`endif
  );

  gerenciador_atributos #(
    .CLK_HZ(TB_CLK), .W(4), .MAX_ATRIB(TB_MAX), .INICIAL(2),
    .PERIODO_DECAI(TB_PER), .LIMIAR_ALERTA(TB_LIM)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .estado(est_b),
    .saciedade(sac_b), .energia(ene_b), .felicidade(fel_b), .morreu(mor_b)
`ifdef ATRIB_ALERTA_EN
    , .alerta(al_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_n_a = 1'b0;
    #1;
    chk("rst_a sac", sac_a, 10);
    chk("rst_a ene", ene_a, 10);
    chk("rst_a fel", fel_a, 10);
    chk("rst_a morreu", mor_a, 0);
`ifdef ATRIB_ALERTA_EN
    chk("rst_a alerta", al_a, 0);
`endif
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task automatic reset_b();
    @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_sac, m_ene, m_fel, m_run, m_dead, m_cyc, m_alert;

  function automatic int up(input int v);
    return (v + 1 > TB_MAX) ? TB_MAX : v + 1;
  endfunction
  function automatic int dn(input int v);
    return (v - 1 < 0) ? 0 : v - 1;
  endfunction

  task automatic model_reset();
    m_sac = 10; m_ene = 10; m_fel = 10;
    m_run = 0; m_dead = 0; m_cyc = 0; m_alert = 0;
  endtask

  // Predicts the state after the next rising edge, given estado held across it.
  task automatic model_step(input logic [3:0] e);
    int is_tick, dead_nx, al_nx;
    is_tick = ((m_cyc % TB_CLK) == TB_CLK - 1) ? 1 : 0;
    dead_nx = (m_dead != 0 || m_sac == 0 || m_ene == 0 || m_fel == 0) ? 1 : 0;
    al_nx   = (m_sac <= TB_LIM ? 1 : 0) + (m_ene <= TB_LIM ? 2 : 0) + (m_fel <= TB_LIM ? 4 : 0);
    if (dead_nx != 0) al_nx = 7;
    if (e != 4'b0001) m_run = 0;
    if (m_dead == 0 && is_tick != 0) begin
      case (e)
        4'b0001: begin
          m_run++;
          if (m_run == TB_PER) begin
            m_sac = dn(m_sac); m_ene = dn(m_ene); m_fel = dn(m_fel);
            m_run = 0;
          end
        end
        4'b0010: m_sac = up(m_sac);
        4'b0100: m_ene = up(m_ene);
        4'b1000: begin m_fel = up(m_fel); m_ene = dn(m_ene); end
        default: ;
      endcase
    end
    m_dead  = dead_nx;
    m_alert = al_nx;
    m_cyc++;
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] est;
    int         ticks;
    int         sac, ene, fel, mor;
  } vec_t;

  vec_t vecs[12];

  logic [3:0] pool [8];

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    est_a = 4'b0001; est_b = 4'b0001;

    vecs[0]  = '{1'b1, 4'b0001, 2, 9, 9, 9, 0};
    vecs[1]  = '{1'b0, 4'b0001, 2, 8, 8, 8, 0};
    vecs[2]  = '{1'b1, 4'b0010, 5, 15, 10, 10, 0};
    vecs[3]  = '{1'b0, 4'b0010, 3, 15, 10, 10, 0};
    vecs[4]  = '{1'b1, 4'b1000, 3, 10, 7, 13, 0};
    vecs[5]  = '{1'b0, 4'b0100, 2, 10, 9, 13, 0};
    vecs[6]  = '{1'b0, 4'b0101, 2, 10, 9, 13, 0};
    vecs[7]  = '{1'b0, 4'b0000, 1, 10, 9, 13, 0};
    vecs[8]  = '{1'b1, 4'b0001, 1, 10, 10, 10, 0};
    vecs[9]  = '{1'b0, 4'b0010, 1, 11, 10, 10, 0};
    vecs[10] = '{1'b0, 4'b0001, 1, 11, 10, 10, 0};
    vecs[11] = '{1'b0, 4'b0001, 1, 10, 9, 9, 0};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) reset_a();
      est_a = vecs[i].est;
      step(vecs[i].ticks * TB_CLK);
      chk($sformatf("vec%0d sac", i), sac_a, vecs[i].sac);
      chk($sformatf("vec%0d ene", i), ene_a, vecs[i].ene);
      chk($sformatf("vec%0d fel", i), fel_a, vecs[i].fel);
      chk($sformatf("vec%0d morreu", i), mor_a, vecs[i].mor);
    end

    // First tick lands exactly CLK_HZ edges after release.
    reset_a();
    est_a = 4'b0010;
    step(TB_CLK - 1);
    chk("first tick early sac", sac_a, 10);
    step(1);
    chk("first tick sac", sac_a, 11);

    // Death with INICIAL=2 while teaching.
    reset_b();
    est_b = 4'b1000;
    step(2 * TB_CLK - 1);
    chk("death pre ene", ene_b, 1);
    step(1);
    chk("death ene zero", ene_b, 0);
    chk("death fel", fel_b, 4);
    chk("death morreu latency", mor_b, 0);
    step(1);
    chk("death morreu", mor_b, 1);
    est_b = 4'b0010;
    step(4 * TB_CLK);
    chk("frozen sac", sac_b, 2);
    chk("frozen ene", ene_b, 0);
    chk("frozen fel", fel_b, 4);
    chk("frozen morreu", mor_b, 1);
`ifdef ATRIB_ALERTA_EN
    chk("frozen alerta", al_b, 7);
`endif

    // Asynchronous reset from MORTO, asserted mid-cycle.
    #2;
    rst_n_b = 1'b0;
    #1;
    chk("async rst sac", sac_b, 2);
    chk("async rst ene", ene_b, 2);
    chk("async rst fel", fel_b, 2);
    chk("async rst morreu", mor_b, 0);
    @(negedge clk);
    rst_n_b = 1'b1;
    step(TB_CLK - 1);
    chk("post rst no tick", sac_b, 2);
    step(1);
    chk("post rst tick", sac_b, 3);
    chk("post rst morreu", mor_b, 0);

`ifdef ATRIB_ALERTA_EN
    reset_a();
    est_a = 4'b1000;
    step(7 * TB_CLK);
    chk("alert ene3", ene_a, 3);
    chk("alert lag", al_a, 0);
    step(1);
    chk("alert set", al_a, 2);
    step(TB_CLK - 1);
    chk("alert ene2", ene_a, 2);
    chk("alert hold", al_a, 2);
    step(2 * TB_CLK);
    chk("alert ene0", ene_a, 0);
    step(1);
    chk("alert death morreu", mor_a, 1);
    chk("alert death", al_a, 7);
`endif

    // Randomized run against the reference model.
    pool[0] = 4'b0001; pool[1] = 4'b0010; pool[2] = 4'b0100; pool[3] = 4'b1000;
    pool[4] = 4'b1000; pool[5] = 4'b0001; pool[6] = 4'b0000; pool[7] = 4'b0110;
    reset_a();
    model_reset();
    est_a = 4'b0001;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_a();
        model_reset();
      end
      if ($urandom_range(0, 3) == 0) est_a = pool[$urandom_range(0, 7)];
      model_step(est_a);
      step(1);
      chk("rand sac", sac_a, m_sac);
      chk("rand ene", ene_a, m_ene);
      chk("rand fel", fel_a, m_fel);
      chk("rand morreu", mor_a, m_dead);
`ifdef ATRIB_ALERTA_EN
      chk("rand alerta", al_a, m_alert);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
